reg_native_initiator: RTL
=========================

# reg_native_initiator

Single-outstanding initiator for the reg_native_if register bus. It turns a valid/ready command stream, such as one from a CPU bridge or a debug/JTAG host, into one reg_native_if transaction at a time on the upstream port of the top-level regdisp. It waits for the responder's ack, or declares a timeout, and returns the read data and error status on a valid/ready response stream.

## Interface
Parameters:
- ADDR_WIDTH, 64, address width; matches regdisp upstream__addr.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 255, number of cycles without ack before a timeout is declared.
  - Legal range is 1 to 2^16-1.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- Clock and reset:
  - clk, in, 1, single clock.
  - rst, in, 1, reset; synchronous, active-high.
- Command stream:
  - cmd_vld, in, 1, command valid.
  - cmd_rdy, out, 1, command accepted when cmd_vld && cmd_rdy at a clk edge.
  - cmd_addr, in, ADDR_WIDTH, absolute address.
  - cmd_wr, in, 1, 1 = write, 0 = read.
  - cmd_wr_data, in, DATA_WIDTH, write data.
- Response stream:
  - rsp_vld, out, 1, response valid.
  - rsp_rdy, in, 1, response consumed when rsp_vld && rsp_rdy.
  - rsp_rd_data, out, DATA_WIDTH, read data; 0 for writes and for timeouts.
  - rsp_err, out, 1, 1 = timeout.
- reg_native_if initiator side:
  - downstream__req_vld, out, 1, request pulse.
  - downstream__ack_vld, in, 1, ack pulse.
  - downstream__addr, out, ADDR_WIDTH, request address.
  - downstream__wr_en, out, 1, write enable.
  - downstream__rd_en, out, 1, read enable.
  - downstream__wr_data, out, DATA_WIDTH, write data.
  - downstream__rd_data, in, DATA_WIDTH, read data; sampled only when ack_vld = 1.
- Status:
  - busy, out, 1, high in every state except IDLE.

## Operation
FSM states are IDLE, REQ, WAIT and RSP.
- IDLE:
  - cmd_rdy = 1.
  - On handshake, capture addr, wr and wr_data, clear the timeout counter, then go to REQ.
- REQ:
  - Lasts exactly one cycle.
  - downstream__req_vld = 1; addr and wr_data are driven from the captured values.
  - wr_en = captured wr; rd_en = !captured wr.
  - If ack_vld = 1 in this cycle (combinational responder), capture rd_data and go to RSP.
  - Otherwise go to WAIT.
- WAIT:
  - All downstream__* outputs are 0.
  - The counter increments every cycle.
  - ack_vld = 1: capture rd_data (forced to 0 if the transaction is a write), set err = 0, go to RSP.
  - No ack and counter == TIMEOUT_CYCLES-1: set rd_data = 0 and err = 1, go to RSP.
  - Ack and timeout in the same cycle: the ack wins and err = 0.
- RSP:
  - rsp_vld = 1; rsp_rd_data and rsp_err are held stable until rsp_rdy.
  - On handshake, go to IDLE.
  - cmd_rdy = 0, so there are no back-to-back commands.
- Stray acks:
  - ack_vld in IDLE or RSP is ignored and leaves all state unchanged.
  - A late ack after a timeout is therefore dropped.
- Outside REQ, every downstream__* output is 0.

## Timing
- Reset:
  - The FSM returns to IDLE.
  - Every output is 0 except cmd_rdy, which is 1 in the first cycle after reset.
  - The counter and all captured registers are 0.
- Reset mid-transaction aborts it: no response is produced and a subsequent ack is ignored.
- Latency, with the command accepted at edge T:
  - req_vld is high in cycle T+1.
  - An ack in cycle T+k (k ≥ 1) gives rsp_vld from cycle T+k+1.
- Ack window: cycles T+1 through T+TIMEOUT_CYCLES, which includes the REQ cycle.
- Timeout: if no ack arrives in that window, rsp_vld with err = 1 is asserted at T+TIMEOUT_CYCLES+1.
- TIMEOUT_CYCLES = 1: only an ack in the REQ cycle succeeds.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.

## Configuration
- REG_NATIVE_INITIATOR_TIMEOUT_EN defined: the timeout counter and timeout exit behave as described above.
- REG_NATIVE_INITIATOR_TIMEOUT_EN undefined:
  - The counter is not built and WAIT exits only on ack.
  - rsp_err is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- reg_native_initiator_pkg holds:
  - the state enum (IDLE, REQ, WAIT, RSP), 2 bits;
  - the rsp_err encoding constants (ERR_NONE = 0, ERR_TIMEOUT = 1).
- Sub-module reg_native_timeout_cnt is a parameterised up-counter.
  - Ports: clr, inc, expired.
  - It is instantiated only under REG_NATIVE_INITIATOR_TIMEOUT_EN.

## Test plan
- Write, ack 3 cycles after req: write 0x1000 with data 0xA5A5_5A5A.
  - Exactly one req_vld cycle, with wr_en = 1, rd_en = 0, addr = 0x1000.
  - rsp_vld follows one cycle after ack, with err = 0 and rd_data = 0.
- Read, ack in the same cycle as req_vld, rd_data = 0xDEAD_BEEF: rsp_vld at T+2 with rd_data = 0xDEAD_BEEF.
- Read with no ack, TIMEOUT_CYCLES = 8:
  - rsp_vld at T+9 with err = 1 and rd_data = 0.
  - A stray ack at T+12 is ignored and the next command proceeds normally.
- Ack and timeout in the same cycle (ack at T+8, TIMEOUT_CYCLES = 8): err = 0 and rd_data is captured.
- Backpressure: hold rsp_rdy = 0 for 5 cycles.
  - rsp_vld, rsp_rd_data and rsp_err stay stable.
  - cmd_rdy = 0 throughout the 5 cycles.
  - cmd_rdy = 1 in the cycle after the rsp handshake.
- Reset asserted in WAIT:
  - IDLE follows, with all outputs at reset values.
  - A subsequent ack_vld produces no rsp_vld.

Source files
------------

// File: rtl/reg_native_initiator_pkg.sv
// Shared types and constants for the reg_native_if single-outstanding initiator.
package reg_native_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_t;

  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/reg_native_timeout_cnt.sv
// Up-counter that flags the last cycle of the ack window.
// expired is high while the count sits at LIMIT-1; the count holds there.
module reg_native_timeout_cnt #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count cycles spent waiting for ack; clear on a new command.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/reg_native_initiator.sv
// reg_native_initiator: one reg_native_if transaction at a time from a
// valid/ready command stream, answered on a valid/ready response stream.
// Optional timeout: define REG_NATIVE_INITIATOR_TIMEOUT_EN to build the
// ack-window counter; otherwise WAIT exits only on ack and rsp_err is 0.
module reg_native_initiator
  import reg_native_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_wr,
  input  logic [DATA_WIDTH-1:0] cmd_wr_data,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rd_data,
  output logic                  rsp_err,
  output logic                  downstream__req_vld,
  input  logic                  downstream__ack_vld,
  output logic [ADDR_WIDTH-1:0] downstream__addr,
  output logic                  downstream__wr_en,
  output logic                  downstream__rd_en,
  output logic [DATA_WIDTH-1:0] downstream__wr_data,
  input  logic [DATA_WIDTH-1:0] downstream__rd_data,
  output logic                  busy
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic w_cmd_hs;
  logic w_in_flight;
  logic w_ack_take;
  logic w_expired;
  logic w_timeout;

  assign w_cmd_hs    = (r_state == IDLE) && cmd_vld;
  assign w_in_flight = (r_state == REQ) || (r_state == WAIT);
  assign w_ack_take  = w_in_flight && downstream__ack_vld;
  assign w_timeout   = w_in_flight && !downstream__ack_vld && w_expired;

`ifdef REG_NATIVE_INITIATOR_TIMEOUT_EN
  logic r_err;

  // The counter also runs in REQ so the window spans REQ plus WAIT;
  // with TIMEOUT_CYCLES = 1 the REQ cycle itself is the last chance.
  reg_native_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_cmd_hs),
    .inc    (w_in_flight),
    .expired(w_expired)
  );

  // Error status of the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst || w_cmd_hs) begin
      r_err <= ERR_NONE;
    end else if (w_ack_take) begin
      r_err <= ERR_NONE;
    end else if (w_timeout) begin
      r_err <= ERR_TIMEOUT;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; ack takes priority over timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (cmd_vld) w_next = REQ;
      REQ, WAIT: begin
        if (downstream__ack_vld || w_expired) w_next = RSP;
        else                                  w_next = WAIT;
      end
      RSP:       if (rsp_rdy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Command capture and read-data capture; stray acks never reach here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wr_data <= '0;
      r_rd_data <= '0;
    end else if (w_cmd_hs) begin
      r_addr    <= cmd_addr;
      r_wr      <= cmd_wr;
      r_wr_data <= cmd_wr_data;
      r_rd_data <= '0;
    end else if (w_ack_take) begin
      r_rd_data <= r_wr ? '0 : downstream__rd_data;
    end else if (w_timeout) begin
      r_rd_data <= '0;
    end
  end

  // Output decode from state and captured registers only.
  always_comb begin
    cmd_rdy             = 1'b0;
    busy                = 1'b1;
    rsp_vld             = 1'b0;
    rsp_rd_data         = '0;
    rsp_err             = ERR_NONE;
    downstream__req_vld = 1'b0;
    downstream__addr    = '0;
    downstream__wr_en   = 1'b0;
    downstream__rd_en   = 1'b0;
    downstream__wr_data = '0;
    unique case (r_state)
      IDLE: begin
        cmd_rdy = 1'b1;
        busy    = 1'b0;
      end
      REQ: begin
        downstream__req_vld = 1'b1;
        downstream__addr    = r_addr;
        downstream__wr_en   = r_wr;
        downstream__rd_en   = !r_wr;
        downstream__wr_data = r_wr_data;
      end
      RSP: begin
        rsp_vld     = 1'b1;
        rsp_rd_data = r_rd_data;
`ifdef REG_NATIVE_INITIATOR_TIMEOUT_EN
        rsp_err     = r_err;
`endif
      end
      default: ;
    endcase
  end

endmodule
